// File: rtl/card_datapath.sv
// Baccarat hand datapath: deal source, six card registers, hand scoring and load bookkeeping.
// Define CARD_DATAPATH_LFSR_EN to replace the wrap-around deal counter with an 8-bit LFSR deal source.
module card_datapath #(
    parameter int DECK_MAX = 13,
    parameter int FACE_MIN = 10
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    output logic [3:0] pcard1_out,
    output logic [3:0] pcard2_out,
    output logic [3:0] pcard3_out,
    output logic [3:0] dcard1_out,
    output logic [3:0] dcard2_out,
    output logic [3:0] dcard3_out,
    output logic [3:0] pcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic [2:0] cards_dealt,
    output logic       load_err
);

    // Slots are stored in strobe-priority order: p1, d1, p2, d2, p3, d3.
    logic [3:0] r_cards [6];
    logic [2:0] r_dealt;
    logic       r_err;
    logic [3:0] w_deal;
    logic [5:0] w_strobes;
    logic [2:0] w_sel_idx;
    logic       w_sel_valid;
    logic       w_multi;
    logic       w_slot_full;
    logic [4:0] w_psum;
    logic [4:0] w_dsum;

`ifdef CARD_DATAPATH_LFSR_EN
    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge slow_clock) begin
        if (resetb) begin
            r_lfsr <= 8'h01;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

    assign w_deal = 4'((r_lfsr % 8'(DECK_MAX)) + 8'd1);
`else
    logic [3:0] r_count;

    always_ff @(posedge slow_clock) begin
        if (resetb) begin
            r_count <= 4'd1;
        end else begin
            r_count <= (r_count == 4'(DECK_MAX)) ? 4'd1 : r_count + 4'd1;
        end
    end

    assign w_deal = r_count;
`endif

    assign w_strobes = {load_dcard3, load_pcard3, load_dcard2,
                        load_pcard2, load_dcard1, load_pcard1};

    // Bit 0 has the highest priority, so the lowest set bit wins.
    always_comb begin
        w_sel_idx   = 3'd0;
        w_sel_valid = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            if (w_strobes[i]) begin
                w_sel_idx   = 3'(i);
                w_sel_valid = 1'b1;
            end
        end
    end

    assign w_multi     = (w_strobes & (w_strobes - 6'd1)) != 6'd0;
    assign w_slot_full = r_cards[w_sel_idx] != 4'd0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge slow_clock) begin
        if (resetb) begin
            // NOTE: the card array is only six registers, so it is cleared explicitly on reset.
            for (int i = 0; i < 6; i++) begin
                r_cards[i] <= 4'd0;
            end
            r_dealt <= 3'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_sel_valid) begin
                r_cards[w_sel_idx] <= w_deal;
                if (!w_slot_full) begin
                    r_dealt <= r_dealt + 3'd1;
                end
            end
            if (w_multi || (w_sel_valid && w_slot_full)) begin
                r_err <= 1'b1;
            end
        end
    end

    function automatic logic [4:0] card_value(input logic [3:0] c);
        if (c != 4'd0 && int'(c) < FACE_MIN) begin
            return {1'b0, c};
        end
        return 5'd0;
    endfunction

    assign w_psum = card_value(r_cards[0]) + card_value(r_cards[2]) + card_value(r_cards[4]);
    assign w_dsum = card_value(r_cards[1]) + card_value(r_cards[3]) + card_value(r_cards[5]);

    assign pscore      = 4'(w_psum % 5'd10);
    assign dscore      = 4'(w_dsum % 5'd10);
    assign pcard1_out  = r_cards[0];
    assign dcard1_out  = r_cards[1];
    assign pcard2_out  = r_cards[2];
    assign dcard2_out  = r_cards[3];
    assign pcard3_out  = r_cards[4];
    assign dcard3_out  = r_cards[5];
    assign pcard3      = r_cards[4];
    assign cards_dealt = r_dealt;
    assign load_err    = r_err;

endmodule

// File: tb/tb_card_datapath.sv
// Bench for card_datapath: directed hand scenarios, then random strobes checked against a rule-level model.
module tb_card_datapath;

    logic       slow_clock = 1'b0;
    logic       resetb = 1'b0;
    logic       load_pcard1 = 1'b0, load_pcard2 = 1'b0, load_pcard3 = 1'b0;
    logic       load_dcard1 = 1'b0, load_dcard2 = 1'b0, load_dcard3 = 1'b0;
    logic [3:0] pcard1_out, pcard2_out, pcard3_out;
    logic [3:0] dcard1_out, dcard2_out, dcard3_out;
    logic [3:0] pcard3, pscore, dscore;
    logic [2:0] cards_dealt;
    logic       load_err;

    int n_checks = 0;
    int n_errors = 0;

    // Model state, indexed by name: 0 p1, 1 p2, 2 p3, 3 d1, 4 d2, 5 d3.
    int m_cards [6];
    int m_edges;
    int m_dealt;
    int m_err;

    localparam int PRIO [6] = '{0, 3, 1, 4, 2, 5};

    card_datapath dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .load_pcard1(load_pcard1),
        .load_pcard2(load_pcard2),
        .load_pcard3(load_pcard3),
        .load_dcard1(load_dcard1),
        .load_dcard2(load_dcard2),
        .load_dcard3(load_dcard3),
        .pcard1_out (pcard1_out),
        .pcard2_out (pcard2_out),
        .pcard3_out (pcard3_out),
        .dcard1_out (dcard1_out),
        .dcard2_out (dcard2_out),
        .dcard3_out (dcard3_out),
        .pcard3     (pcard3),
        .pscore     (pscore),
        .dscore     (dscore),
        .cards_dealt(cards_dealt),
        .load_err   (load_err)
    );

    always #5 slow_clock = ~slow_clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int score(input int a, input int b, input int c);
        int s = 0;
        int v [3];
        v = '{a, b, c};
        foreach (v[k]) if (v[k] >= 1 && v[k] <= 9) s += v[k];
        return s % 10;
    endfunction

    // Apply inputs, take one rising edge, advance the model, then settle before sampling.
    task automatic tick(input bit rst, input logic [5:0] loads);
        int deal;
        int first;
        int nset;
        resetb      = rst;
        load_pcard1 = loads[0];
        load_pcard2 = loads[1];
        load_pcard3 = loads[2];
        load_dcard1 = loads[3];
        load_dcard2 = loads[4];
        load_dcard3 = loads[5];
        @(posedge slow_clock);
        #1;
        if (rst) begin
            foreach (m_cards[k]) m_cards[k] = 0;
            m_edges = 0;
            m_dealt = 0;
            m_err   = 0;
        end else begin
            deal  = (m_edges % 13) + 1;
            first = -1;
            nset  = 0;
            for (int k = 0; k < 6; k++) begin
                if (loads[PRIO[k]]) begin
                    nset++;
                    if (first < 0) first = PRIO[k];
                end
            end
            if (nset > 1) m_err = 1;
            if (first >= 0) begin
                if (m_cards[first] != 0) m_err = 1;
                else m_dealt++;
                m_cards[first] = deal;
            end
            m_edges++;
        end
        resetb = 1'b0;
        {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = 6'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 6'b0);
    endtask

    task automatic compare_model();
        check("pcard1", pcard1_out, m_cards[0]);
        check("pcard2", pcard2_out, m_cards[1]);
        check("pcard3_out", pcard3_out, m_cards[2]);
        check("dcard1", dcard1_out, m_cards[3]);
        check("dcard2", dcard2_out, m_cards[4]);
        check("dcard3", dcard3_out, m_cards[5]);
        check("pcard3", pcard3, m_cards[2]);
        check("pscore", pscore, score(m_cards[0], m_cards[1], m_cards[2]));
        check("dscore", dscore, score(m_cards[3], m_cards[4], m_cards[5]));
        check("cards_dealt", cards_dealt, m_dealt);
        check("load_err", load_err, m_err);
    endtask

    initial begin
        logic [5:0] loads;
        int r;

        // Reset state.
        tick(1'b1, 6'b0);
        check("rst_pcard1", pcard1_out, 0);
        check("rst_dcard3", dcard3_out, 0);
        check("rst_pscore", pscore, 0);
        check("rst_dscore", dscore, 0);
        check("rst_pcard3", pcard3, 0);
        check("rst_dealt", cards_dealt, 0);
        check("rst_err", load_err, 0);

        // Four consecutive single loads.
        tick(1'b0, 6'b000001);
        tick(1'b0, 6'b001000);
        tick(1'b0, 6'b000010);
        tick(1'b0, 6'b010000);
        check("seq_pcard1", pcard1_out, 1);
        check("seq_dcard1", dcard1_out, 2);
        check("seq_pcard2", pcard2_out, 3);
        check("seq_dcard2", dcard2_out, 4);
        check("seq_pscore", pscore, 4);
        check("seq_dscore", dscore, 6);
        check("seq_dealt", cards_dealt, 4);
        check("seq_err", load_err, 0);

        // Counter reaches DECK_MAX, then wraps to 1.
        tick(1'b1, 6'b0);
        idle(12);
        tick(1'b0, 6'b000100);
        check("max_pcard3", pcard3, 13);
        check("max_pscore", pscore, 0);
        tick(1'b0, 6'b100000);
        check("wrap_dcard3", dcard3_out, 1);
        check("wrap_dscore", dscore, 1);

        // Score reduced mod 10.
        tick(1'b1, 6'b0);
        idle(6);
        tick(1'b0, 6'b000001);
        check("mod_pcard1", pcard1_out, 7);
        tick(1'b0, 6'b000010);
        check("mod_pcard2", pcard2_out, 8);
        check("mod_pscore", pscore, 5);
        check("mod_dealt", cards_dealt, 2);

        // Simultaneous strobes: dcard1 outranks pcard2.
        tick(1'b1, 6'b0);
        tick(1'b0, 6'b001010);
        check("multi_dcard1", dcard1_out, 1);
        check("multi_pcard2", pcard2_out, 0);
        check("multi_err", load_err, 1);
        check("multi_dealt", cards_dealt, 1);
        idle(20);
        check("sticky_err", load_err, 1);

        // Reload overwrites without counting.
        tick(1'b1, 6'b0);
        tick(1'b0, 6'b000001);
        tick(1'b0, 6'b000001);
        check("reload_pcard1", pcard1_out, 2);
        check("reload_dealt", cards_dealt, 1);
        check("reload_err", load_err, 1);

        // Mid-hand reset.
        tick(1'b1, 6'b0);
        tick(1'b0, 6'b000001);
        tick(1'b0, 6'b001000);
        tick(1'b0, 6'b000011);
        tick(1'b1, 6'b000111);
        compare_model();
        check("midrst_dealt", cards_dealt, 0);
        check("midrst_err", load_err, 0);
        check("midrst_pscore", pscore, 0);
        tick(1'b0, 6'b000001);
        check("midrst_pcard1", pcard1_out, 1);

        // Random strobes against the model.
        for (int c = 0; c < 400; c++) begin
            r = int'($urandom_range(0, 15));
            if (r < 6) loads = 6'(1 << r);
            else if (r < 10) loads = 6'b0;
            else loads = 6'($urandom);
            tick($urandom_range(0, 39) == 0, loads);
            compare_model();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
